brush_cursor_ctrl: RTL and testbench

Consumes the periodic single-cycle step strobe from the frequency divider and moves a brush cursor over the drawing canvas from four direction buttons.
- Holding a button accelerates the step size.
- When drawing is enabled, one framebuffer write is issued per step at the cursor position.
- A clear request sweeps the whole framebuffer to zero.
- Sits between the divider and the VGA framebuffer write port.

---
 rtl/brush_cursor_ctrl_if.sv | 32 +++
 rtl/brush_cursor_ctrl.sv | 149 ++++++++++++++
 tb/tb_brush_cursor_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/brush_cursor_ctrl_if.sv
// Bundle between the step divider, the front-panel controls and the framebuffer write port.
// The master drives the strobe and controls; the slave drives the cursor and write port.
interface brush_cursor_ctrl_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 12
);
  logic               pulse;
  logic               btn_up;
  logic               btn_down;
  logic               btn_left;
  logic               btn_right;
  logic               draw_en;
  logic               clear;
  logic [COLOR_W-1:0] color;
  logic [X_W-1:0]     cur_x;
  logic [Y_W-1:0]     cur_y;
  logic               wr_en;
  logic [X_W+Y_W-1:0] wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               busy;

  modport master (
    output pulse, btn_up, btn_down, btn_left, btn_right, draw_en, clear, color,
    input  cur_x, cur_y, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  pulse, btn_up, btn_down, btn_left, btn_right, draw_en, clear, color,
    output cur_x, cur_y, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/brush_cursor_ctrl.sv
// Brush cursor mover with hold-to-accelerate stepping, paint-on-step writes and a
// full-canvas clear sweep driving the framebuffer write port.
module brush_cursor_ctrl #(
  parameter int X_W        = 8,
  parameter int Y_W        = 8,
  parameter int ACCEL_HOLD = 16,
  parameter int ACCEL_STEP = 4,
  parameter int COLOR_W    = 12
) (
  input  logic               Origin_Clock,
  input  logic               reset,
  brush_cursor_ctrl_if.slave bus
);
  localparam int A_W  = X_W + Y_W;
  localparam int HC_W = $clog2(ACCEL_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(ACCEL_HOLD);
  localparam logic [X_W:0]    X_MAX    = {1'b0, {X_W{1'b1}}};
  localparam logic [Y_W:0]    Y_MAX    = {1'b0, {Y_W{1'b1}}};

  typedef enum logic {IDLE, CLEAR} state_t;

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 draw_en, 5 clear
  logic [5:0] async_in;
  logic [5:0] sync1_q, sync2_q;
  logic       clr_prev_q;

  state_t             state_q, state_d;
  logic [X_W-1:0]     cur_x_q, cur_x_d;
  logic [Y_W-1:0]     cur_y_q, cur_y_d;
  logic [HC_W-1:0]    hold_q, hold_d;
  logic               wr_en_q, wr_en_d;
  logic [A_W-1:0]     wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0] wr_data_q, wr_data_d;
  logic               busy_q, busy_d;

  logic           up_s, down_s, left_s, right_s, draw_s, clr_rise, dir_any;
  logic [X_W:0]   step_x, sum_x;
  logic [Y_W:0]   step_y, sum_y;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;

  assign async_in = {bus.clear, bus.draw_en, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  assign up_s     = sync2_q[0];
  assign down_s   = sync2_q[1];
  assign left_s   = sync2_q[2];
  assign right_s  = sync2_q[3];
  assign draw_s   = sync2_q[4];
  assign clr_rise = sync2_q[5] & ~clr_prev_q;
  // Opposing buttons cancel, so they do not count as a held direction.
  assign dir_any  = (left_s ^ right_s) | (up_s ^ down_s);

  // Candidate position for a step: widened by one bit so the upper clamp sees the carry.
  always_comb begin
    step_x = (hold_q < HOLD_MAX) ? (X_W+1)'(1) : (X_W+1)'(ACCEL_STEP);
    step_y = (hold_q < HOLD_MAX) ? (Y_W+1)'(1) : (Y_W+1)'(ACCEL_STEP);
    sum_x  = {1'b0, cur_x_q} + step_x;
    sum_y  = {1'b0, cur_y_q} + step_y;
    nx     = cur_x_q;
    ny     = cur_y_q;
    if (right_s && !left_s) begin
      nx = (sum_x > X_MAX) ? '1 : sum_x[X_W-1:0];
    end else if (left_s && !right_s) begin
      nx = ({1'b0, cur_x_q} < step_x) ? '0 : cur_x_q - step_x[X_W-1:0];
    end
    if (down_s && !up_s) begin
      ny = (sum_y > Y_MAX) ? '1 : sum_y[Y_W-1:0];
    end else if (up_s && !down_s) begin
      ny = ({1'b0, cur_y_q} < step_y) ? '0 : cur_y_q - step_y[Y_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    hold_d    = hold_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (clr_rise) begin
          // A pulse coinciding with the clear edge is dropped entirely.
          state_d   = CLEAR;
          busy_d    = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
        end else if (bus.pulse) begin
          cur_x_d = nx;
          cur_y_d = ny;
          if (!dir_any)              hold_d = '0;
          else if (hold_q < HOLD_MAX) hold_d = hold_q + HC_W'(1);
          if (draw_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {ny, nx};
            wr_data_d = bus.color;
          end
        end
      end
      CLEAR: begin
        if (wr_addr_q == '1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + A_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Origin_Clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      clr_prev_q <= 1'b0;
      state_q    <= IDLE;
      cur_x_q    <= {1'b1, {(X_W-1){1'b0}}};
      cur_y_q    <= {1'b1, {(Y_W-1){1'b0}}};
      hold_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= async_in;
      sync2_q    <= sync1_q;
      clr_prev_q <= sync2_q[5];
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      hold_q     <= hold_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cur_x   = cur_x_q;
  assign bus.cur_y   = cur_y_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_brush_cursor_ctrl.sv
// Bench for brush_cursor_ctrl: vector table, hand sequences for acceleration, clamping and
// the clear sweep, then randomised steps against an arithmetic cursor model.
module tb_brush_cursor_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  brush_cursor_ctrl_if #(.X_W(8), .Y_W(8), .COLOR_W(12)) bus ();

  brush_cursor_ctrl #(
    .X_W(8), .Y_W(8), .ACCEL_HOLD(16), .ACCEL_STEP(4), .COLOR_W(12)
  ) dut (
    .Origin_Clock(clk),
    .reset(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int m_x, m_y, m_hold;

  typedef struct {
    bit u, d, l, r, draw;
    logic [11:0] color;
    int ex, ey;
    bit ewr;
    int eaddr;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_x = 128; m_y = 128; m_hold = 0;
  endtask

  // One step of the cursor rules in plain integer arithmetic.
  task automatic model_pulse(input bit u, input bit d, input bit l, input bit r);
    int dx, dy, step;
    dx   = int'(r) - int'(l);
    dy   = int'(d) - int'(u);
    step = (m_hold < 16) ? 1 : 4;
    if (dx != 0 || dy != 0) m_hold = (m_hold + 1 > 16) ? 16 : m_hold + 1;
    else                    m_hold = 0;
    m_x = clampi(m_x + dx * step, 255);
    m_y = clampi(m_y + dy * step, 255);
  endtask

  task automatic set_inputs(input bit u, input bit d, input bit l, input bit r,
                            input bit dr, input logic [11:0] c);
    bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
    bus.draw_en = dr; bus.color = c;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Raise pulse for one cycle; returns #1 after the edge that captured it.
  task automatic pulse_only();
    bus.pulse = 1'b1;
    @(posedge clk); #1;
    bus.pulse = 1'b0;
  endtask

  task automatic step_check(input string tag);
    pulse_only();
    model_pulse(bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right);
    chk({tag, " cur_x"}, int'(bus.cur_x), m_x);
    chk({tag, " cur_y"}, int'(bus.cur_y), m_y);
    chk({tag, " wr_en"}, int'(bus.wr_en), int'(bus.draw_en));
    if (bus.draw_en) begin
      chk({tag, " wr_addr"}, int'(bus.wr_addr), m_y * 256 + m_x);
      chk({tag, " wr_data"}, int'(bus.wr_data), int'(bus.color));
    end
    @(posedge clk); #1;
    chk({tag, " wr_en_drop"}, int'(bus.wr_en), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int bad, first_bad, found;
  bit ru, rd, rl, rr, rdr;
  logic [11:0] rc;

  initial begin
    tbl[0] = '{0, 1, 0, 0, 1, 12'hF00, 128, 129, 1, 'h8180};
    tbl[1] = '{0, 0, 0, 1, 0, 12'h000, 129, 129, 0, 0};
    tbl[2] = '{0, 0, 0, 1, 0, 12'h000, 130, 129, 0, 0};
    tbl[3] = '{1, 1, 0, 0, 1, 12'hABC, 130, 129, 1, 'h8182};
    tbl[4] = '{0, 0, 1, 0, 0, 12'h000, 129, 129, 0, 0};
    tbl[5] = '{1, 0, 1, 1, 0, 12'h000, 129, 128, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 1, 12'h055, 129, 128, 1, 'h8081};

    bus.pulse = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    bus.draw_en = 0; bus.clear = 0; bus.color = '0;
    do_reset();
    chk("rst cur_x", int'(bus.cur_x), 128);
    chk("rst cur_y", int'(bus.cur_y), 128);
    chk("rst wr_en", int'(bus.wr_en), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst wr_addr", int'(bus.wr_addr), 0);
    chk("rst wr_data", int'(bus.wr_data), 0);

    for (int i = 0; i < 7; i++) begin
      set_inputs(tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].draw, tbl[i].color);
      pulse_only();
      model_pulse(tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r);
      chk($sformatf("vec%0d cur_x", i), int'(bus.cur_x), tbl[i].ex);
      chk($sformatf("vec%0d cur_y", i), int'(bus.cur_y), tbl[i].ey);
      chk($sformatf("vec%0d wr_en", i), int'(bus.wr_en), int'(tbl[i].ewr));
      if (tbl[i].ewr) begin
        chk($sformatf("vec%0d wr_addr", i), int'(bus.wr_addr), tbl[i].eaddr);
        chk($sformatf("vec%0d wr_data", i), int'(bus.wr_data), int'(tbl[i].color));
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d wr_en_drop", i), int'(bus.wr_en), 0);
    end

    // Acceleration: 16 single-pixel steps, then 4-pixel steps.
    do_reset();
    set_inputs(0, 0, 0, 1, 0, 12'h000);
    for (int i = 1; i <= 20; i++) begin
      step_check($sformatf("accel%0d", i));
      if (i == 3)  chk("accel x@3", int'(bus.cur_x), 131);
      if (i == 16) chk("accel x@16", int'(bus.cur_x), 144);
    end
    chk("accel x@20", int'(bus.cur_x), 160);
    set_inputs(0, 0, 0, 0, 0, 12'h000);
    step_check("release");
    chk("release x", int'(bus.cur_x), 160);
    set_inputs(0, 0, 0, 1, 0, 12'h000);
    step_check("repress");
    chk("repress x", int'(bus.cur_x), 161);

    // Saturation at the left edge and cancelling vertical buttons.
    do_reset();
    set_inputs(0, 0, 1, 0, 0, 12'h000);
    for (int i = 0; i < 200; i++) step_check($sformatf("left%0d", i));
    chk("left sat x", int'(bus.cur_x), 0);
    set_inputs(1, 1, 0, 0, 1, 12'h123);
    step_check("updown");
    chk("updown y", int'(bus.cur_y), 128);

    // Randomised steps; buttons mostly held so acceleration and clamps get exercised.
    do_reset();
    {ru, rd, rl, rr} = 4'b0001;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) {ru, rd, rl, rr} = 4'($urandom);
      rdr = 1'($urandom);
      rc  = 12'($urandom);
      set_inputs(ru, rd, rl, rr, rdr, rc);
      step_check($sformatf("rnd%0d", it));
    end

    // Clear edge coinciding with a pulse: pulse dropped, full sweep follows.
    set_inputs(0, 0, 0, 1, 0, 12'h000);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.pulse = 1'b1;
    @(posedge clk); #1;
    bus.pulse = 1'b0;
    chk("clr busy", int'(bus.busy), 1);
    chk("clr wr_en", int'(bus.wr_en), 1);
    chk("clr cur_x", int'(bus.cur_x), m_x);
    bad = 0; first_bad = -1;
    for (int i = 0; i < 65536; i++) begin
      if (!(bus.wr_en && bus.busy && int'(bus.wr_addr) == i && bus.wr_data == 12'h000 &&
            int'(bus.cur_x) == m_x && int'(bus.cur_y) == m_y)) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
      bus.pulse = ((i % 37) == 5);
      if (i == 300) bus.clear = 1'b0;
      if (i == 600) bus.clear = 1'b1;
      @(posedge clk); #1;
    end
    bus.pulse = 1'b0;
    chk("sweep bad cycles", bad, 0);
    if (first_bad >= 0) chk("sweep first bad index", first_bad, -1);
    chk("post-sweep wr_en", int'(bus.wr_en), 0);
    chk("post-sweep busy", int'(bus.busy), 0);
    chk("post-sweep cur_x", int'(bus.cur_x), m_x);
    chk("post-sweep cur_y", int'(bus.cur_y), m_y);
    bus.clear = 1'b0;
    set_inputs(0, 0, 0, 1, 0, 12'h000);
    step_check("post-sweep step");

    // Second sweep cut short by reset.
    bus.clear = 1'b1;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(posedge clk); #1;
      if (bus.busy && int'(bus.wr_addr) == 1000) found = 1;
    end
    chk("sweep reached 1000", found, 1);
    rst = 1'b1;
    #1;
    chk("mid-sweep rst wr_en", int'(bus.wr_en), 0);
    chk("mid-sweep rst busy", int'(bus.busy), 0);
    chk("mid-sweep rst cur_x", int'(bus.cur_x), 128);
    chk("mid-sweep rst cur_y", int'(bus.cur_y), 128);
    chk("mid-sweep rst wr_addr", int'(bus.wr_addr), 0);
    bus.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("no resume busy", int'(bus.busy), 0);
    chk("no resume wr_en", int'(bus.wr_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
